digit_scan_mux: RTL and testbench

Time-multiplexed digit scanner that sits directly upstream of the universal decoder. It holds a double-buffered bank of 4-bit digit codes and presents one code per scan slot on `code_out`, which the decoder turns into segment patterns. It drives a one-hot `digit_en` for the common-anode/cathode lines. Each slot is followed by a blanking gap to suppress ghosting. Buffer updates are committed only at frame boundaries so a displayed frame never tears.

---
 rtl/digit_scan_mux.sv | 162 ++++++++++++++++
 tb/tb_digit_scan_mux.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_mux.sv
// Time-multiplexed digit scanner with double-buffered digit codes and a frame-boundary commit.
// Define SCAN_LZ_BLANK_EN to blank leading zero digits (digit NUM_DIGITS-1 is most significant).
module digit_scan_mux #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DWELL      = 1000,
    parameter int unsigned BLANK      = 8,
    localparam int unsigned AW        = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  commit,
    output logic                  commit_pending,
    output logic [3:0]            code_out,
    output logic                  code_valid,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_start
);

    localparam int unsigned CntMax = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned CW     = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CW-1:0] DwellLast = CW'(DWELL - 1);
    localparam logic [CW-1:0] BlankLast = (BLANK > 0) ? CW'(BLANK - 1) : '0;
    localparam logic [AW-1:0] IdxLast   = AW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StDisp, StBlnk} state_e;

    state_e                      state_q, state_d;
    logic [AW-1:0]               idx_q, idx_d, idx_next;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0]  shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0][3:0]  active_q, active_d;
    logic                        commit_pending_q, commit_pending_d;
    logic [3:0]                  code_out_q, code_out_d;
    logic                        code_valid_q, code_valid_d;
    logic [NUM_DIGITS-1:0]       digit_en_q, digit_en_d;
    logic                        frame_start_q, frame_start_d;
    logic                        boundary;
    logic                        lit;
`ifdef SCAN_LZ_BLANK_EN
    logic                        upper_zero;
`endif

    assign idx_next = (idx_q == IdxLast) ? '0 : idx_q + AW'(1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;
        case (state_q)
            StIdle: begin
                if (ena) begin
                    state_d  = StDisp;
                    idx_d    = '0;
                    cnt_d    = '0;
                    boundary = 1'b1;
                end
            end
            StDisp: begin
                if (cnt_q == DwellLast) begin
                    cnt_d = '0;
                    if (BLANK == 0) begin
                        idx_d    = idx_next;
                        boundary = (idx_q == IdxLast);
                    end else begin
                        state_d = StBlnk;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StBlnk: begin
                if (cnt_q == BlankLast) begin
                    state_d  = StDisp;
                    cnt_d    = '0;
                    idx_d    = idx_next;
                    boundary = (idx_q == IdxLast);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (!ena) begin
            state_d  = StIdle;
            idx_d    = '0;
            cnt_d    = '0;
            boundary = 1'b0;
        end
    end

    // The copy reads the pre-write shadow; a same-edge commit re-arms pending.
    always_comb begin
        active_d         = active_q;
        commit_pending_d = commit_pending_q | commit;
        if (boundary && commit_pending_q) begin
            active_d         = shadow_q;
            commit_pending_d = commit;
        end
        shadow_d = shadow_q;
        if (wr_en && (32'(wr_addr) < NUM_DIGITS)) begin
            shadow_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        lit = (state_d == StDisp);
`ifdef SCAN_LZ_BLANK_EN
        upper_zero = 1'b1;
        for (int j = 0; j < int'(NUM_DIGITS); j++) begin
            if ((j >= int'(idx_d)) && (active_d[j] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
        if ((idx_d != '0) && upper_zero) begin
            lit = 1'b0;
        end
`endif
        code_valid_d       = lit;
        digit_en_d         = '0;
        digit_en_d[idx_d]  = lit;
        code_out_d         = lit ? active_d[idx_d] : 4'd0;
        frame_start_d      = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            idx_q            <= '0;
            cnt_q            <= '0;
            shadow_q         <= '0;
            active_q         <= '0;
            commit_pending_q <= 1'b0;
            code_out_q       <= 4'd0;
            code_valid_q     <= 1'b0;
            digit_en_q       <= '0;
            frame_start_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            cnt_q            <= cnt_d;
            shadow_q         <= shadow_d;
            active_q         <= active_d;
            commit_pending_q <= commit_pending_d;
            code_out_q       <= code_out_d;
            code_valid_q     <= code_valid_d;
            digit_en_q       <= digit_en_d;
            frame_start_q    <= frame_start_d;
        end
    end

    assign commit_pending = commit_pending_q;
    assign code_out       = code_out_q;
    assign code_valid     = code_valid_q;
    assign digit_en       = digit_en_q;
    assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Scoreboard bench: two scanners (BLANK=2 and BLANK=0) checked against a frame-position model.
module tb_digit_scan_mux;

    localparam int ND = 4;
    localparam int DW = 5;

    typedef struct {
        int         tag;
        logic [3:0] code;
        logic       valid;
        logic [3:0] en;
        logic       fs;
        logic       pend;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, wr_en, commit;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;

    logic       dut_pend  [2];
    logic [3:0] dut_code  [2];
    logic       dut_valid [2];
    logic [3:0] dut_en    [2];
    logic       dut_fs    [2];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t mx;

    logic [3:0] m_sh  [2][4];
    logic [3:0] m_act [2][4];
    logic       m_pend[2];
    int         m_t   [2];

    digit_scan_mux #(.NUM_DIGITS(ND), .DWELL(DW), .BLANK(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .commit_pending(dut_pend[0]),
        .code_out(dut_code[0]), .code_valid(dut_valid[0]), .digit_en(dut_en[0]),
        .frame_start(dut_fs[0])
    );

    digit_scan_mux #(.NUM_DIGITS(ND), .DWELL(DW), .BLANK(0)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .commit_pending(dut_pend[1]),
        .code_out(dut_code[1]), .code_valid(dut_valid[1]), .digit_en(dut_en[1]),
        .frame_start(dut_fs[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int blank_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < ND; i++) begin
                m_sh[k][i]  = 4'd0;
                m_act[k][i] = 4'd0;
            end
            m_pend[k] = 1'b0;
            m_t[k]    = -1;
        end
    endtask

    // t = cycles since the first lit cycle of the current frame; -1 when not scanning.
    task automatic model_step(input int k, input logic e, input logic we, input logic [1:0] wa,
                              input logic [3:0] wd, input logic cm, output exp_t x);
        int   slot, per, pos, d;
        logic lit, nz;
        slot = DW + blank_of(k);
        per  = ND * slot;
        if (!e) m_t[k] = -1;
        else    m_t[k] = (m_t[k] < 0) ? 0 : (m_t[k] + 1) % per;
        if (e && m_t[k] == 0 && m_pend[k]) begin
            for (int i = 0; i < ND; i++) m_act[k][i] = m_sh[k][i];
            m_pend[k] = cm;
        end else begin
            m_pend[k] = m_pend[k] | cm;
        end
        if (we) m_sh[k][wa] = wd;
        pos = (m_t[k] < 0) ? 0 : m_t[k];
        d   = pos / slot;
        lit = (m_t[k] >= 0) && ((pos % slot) < DW);
`ifdef SCAN_LZ_BLANK_EN
        if (lit && d > 0) begin
            nz = 1'b0;
            for (int j = d; j < ND; j++) if (m_act[k][j] != 4'd0) nz = 1'b1;
            if (!nz) lit = 1'b0;
        end
`else
        nz = 1'b1;
`endif
        x.tag   = cyc + 1;
        x.valid = lit;
        x.code  = lit ? m_act[k][d] : 4'd0;
        x.en    = lit ? 4'(1 << d) : 4'd0;
        x.fs    = (m_t[k] == 0);
        x.pend  = m_pend[k];
    endtask

    task automatic step(input logic e, input logic we, input logic [1:0] wa,
                        input logic [3:0] wd, input logic cm);
        exp_t x;
        ena = e; wr_en = we; wr_addr = wa; wr_data = wd; commit = cm;
        model_step(0, e, we, wa, wd, cm, x);
        q0.push_back(x);
        model_step(1, e, we, wa, wd, cm, x);
        q1.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
    endtask

    task automatic check(input int k, input string nm, input logic [3:0] code,
                         input logic valid, input logic [3:0] en, input logic fs, input logic pend);
        total++;
        if ({dut_code[k], dut_valid[k], dut_en[k], dut_fs[k], dut_pend[k]} !==
            {code, valid, en, fs, pend}) begin
            bad++;
            $display("FAIL %s scan%0d cyc=%0d got code=%h valid=%b en=%b fs=%b pend=%b want code=%h valid=%b en=%b fs=%b pend=%b",
                     nm, k, cyc, dut_code[k], dut_valid[k], dut_en[k], dut_fs[k], dut_pend[k],
                     code, valid, en, fs, pend);
        end
    endtask

    // Monitor: zero outputs while reset is low, otherwise pop the entry due this cycle.
    always begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            #1;
            for (int k = 0; k < 2; k++) check(k, "reset", 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        end else begin
            while (q0.size() > 0 && q0[0].tag < cyc) begin
                mx = q0.pop_front();
                total++; bad++;
                $display("FAIL stale0 tag=%0d cyc=%0d", mx.tag, cyc);
            end
            while (q1.size() > 0 && q1[0].tag < cyc) begin
                mx = q1.pop_front();
                total++; bad++;
                $display("FAIL stale1 tag=%0d cyc=%0d", mx.tag, cyc);
            end
            if (q0.size() > 0 && q0[0].tag == cyc) begin
                mx = q0.pop_front();
                check(0, "scan", mx.code, mx.valid, mx.en, mx.fs, mx.pend);
            end
            if (q1.size() > 0 && q1[0].tag == cyc) begin
                mx = q1.pop_front();
                check(1, "scan", mx.code, mx.valid, mx.en, mx.fs, mx.pend);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; commit = 1'b0; wr_addr = 2'd0; wr_data = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Empty buffers: plain scan pattern.
        run(60);

        // Load shadow and commit mid-frame.
        step(1'b1, 1'b1, 2'd3, 4'd9, 1'b0);
        step(1'b1, 1'b1, 2'd2, 4'd0, 1'b0);
        step(1'b1, 1'b1, 2'd1, 4'd4, 1'b0);
        step(1'b1, 1'b1, 2'd0, 4'd7, 1'b1);
        for (int i = 0; i < 40 && m_t[0] != ND * (DW + 2) - 1; i++) run(1);
        // Write on the boundary edge while pending: frame shows the old digit 1.
        step(1'b1, 1'b1, 2'd1, 4'd5, 1'b0);
        run(60);
        step(1'b1, 1'b0, 2'd0, 4'd0, 1'b1);
        run(60);

        // Drop enable during digit 2, then resume.
        for (int i = 0; i < 40 && m_t[0] != 2 * (DW + 2) + 1; i++) run(1);
        repeat (3) step(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
        run(40);

        // Asynchronous reset mid-DISP of digit 0.
        for (int i = 0; i < 40 && m_t[0] != 2; i++) run(1);
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(40);

        // Leading-zero patterns.
        step(1'b1, 1'b1, 2'd0, 4'd6, 1'b0);
        step(1'b1, 1'b1, 2'd1, 4'd0, 1'b0);
        step(1'b1, 1'b1, 2'd2, 4'd0, 1'b0);
        step(1'b1, 1'b1, 2'd3, 4'd0, 1'b1);
        run(70);
        step(1'b1, 1'b1, 2'd2, 4'd8, 1'b1);
        run(70);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic       e, we, cm;
            logic [1:0] wa;
            logic [3:0] wd;
            e  = ($urandom_range(0, 99) >= 2);
            we = ($urandom_range(0, 3) == 0);
            wa = 2'($urandom);
            wd = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            cm = ($urandom_range(0, 19) == 0);
            step(e, we, wa, wd, cm);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
